// File: rtl/running_avg_if.sv
// Sample/average bus for the running_avg engine.
//   master: drives run, sample_valid, sample_in; observes the average side.
//   slave : the engine; consumes samples, drives avg_out, avg_valid, cnt_en,
//           fill_level.
interface running_avg_if #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned LOG2_WIN = 3
);
    logic                run;
    logic                sample_valid;
    logic [DATA_W-1:0]   sample_in;
    logic [DATA_W-1:0]   avg_out;
    logic                avg_valid;
    logic                cnt_en;
    logic [LOG2_WIN:0]   fill_level;

    modport master (
        output run, sample_valid, sample_in,
        input  avg_out, avg_valid, cnt_en, fill_level
    );

    modport slave (
        input  run, sample_valid, sample_in,
        output avg_out, avg_valid, cnt_en, fill_level
    );
endinterface

// File: rtl/running_avg.sv
// Sliding-window running average over the last 2^LOG2_WIN accepted samples.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : running_avg_if slave modport
//           run          level, 1 = active, 0 = flush/idle
//           sample_valid sample_in valid this cycle
//           sample_in    unsigned sample
//           avg_out      window average, held between updates
//           avg_valid    1-cycle pulse when avg_out updates (full window only)
//           cnt_en       level enable for the downstream average counter
//           fill_level   samples held in the window, saturates at WIN
// Build option: define RUNNING_AVG_ROUND_EN for round-half-up averaging;
// default truncates.
module running_avg #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned LOG2_WIN = 3
) (
    input logic          clk,
    input logic          rst_n,
    running_avg_if.slave bus
);
    localparam int unsigned Win   = 1 << LOG2_WIN;
    localparam int unsigned SumW  = DATA_W + LOG2_WIN;
    localparam int unsigned FillW = LOG2_WIN + 1;

    localparam logic [FillW-1:0]    FillMax = FillW'(Win);
    localparam logic [FillW-1:0]    FillOne = FillW'(1);
    localparam logic [LOG2_WIN-1:0] WpOne   = LOG2_WIN'(1);

    logic [DATA_W-1:0]   buf_q [Win];
    logic [DATA_W-1:0]   buf_d [Win];
    logic [LOG2_WIN-1:0] wp_q, wp_d;
    logic [SumW-1:0]     sum_q, sum_d;
    logic [FillW-1:0]    fill_q, fill_d;
    logic [DATA_W-1:0]   avg_q, avg_d;
    logic                avg_valid_q, avg_valid_d;
    logic                cnt_en_q, cnt_en_d;

    logic                accept;
    logic [SumW-1:0]     sum_next;
    logic [FillW-1:0]    fill_next;
    logic [DATA_W-1:0]   avg_calc;

    assign accept = bus.run & bus.sample_valid;

    // Oldest entry drops out as the new one enters; empty slots hold 0.
    assign sum_next  = sum_q + SumW'(bus.sample_in) - SumW'(buf_q[wp_q]);
    assign fill_next = (fill_q == FillMax) ? fill_q : fill_q + FillOne;

`ifdef RUNNING_AVG_ROUND_EN
    logic [SumW:0] rnd_sum;
    logic [SumW:0] rnd_shift;

    assign rnd_sum   = {1'b0, sum_next} + (SumW + 1)'(Win / 2);
    assign rnd_shift = rnd_sum >> LOG2_WIN;
    assign avg_calc  = (|rnd_shift[SumW:DATA_W]) ? {DATA_W{1'b1}} : rnd_shift[DATA_W-1:0];
`else
    assign avg_calc = sum_next[SumW-1:LOG2_WIN];
`endif

    always_comb begin
        buf_d       = buf_q;
        wp_d        = wp_q;
        sum_d       = sum_q;
        fill_d      = fill_q;
        avg_d       = avg_q;
        avg_valid_d = 1'b0;
        cnt_en_d    = cnt_en_q;

        if (!bus.run) begin
            // Flush takes priority over any sample presented this cycle.
            for (int i = 0; i < Win; i++) begin
                buf_d[i] = '0;
            end
            wp_d     = '0;
            sum_d    = '0;
            fill_d   = '0;
            cnt_en_d = 1'b0;
        end else if (accept) begin
            buf_d[wp_q] = bus.sample_in;
            wp_d        = wp_q + WpOne;
            sum_d       = sum_next;
            fill_d      = fill_next;
            if (fill_next == FillMax) begin
                avg_d       = avg_calc;
                avg_valid_d = 1'b1;
                cnt_en_d    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < Win; i++) begin
                buf_q[i] <= '0;
            end
            wp_q        <= '0;
            sum_q       <= '0;
            fill_q      <= '0;
            avg_q       <= '0;
            avg_valid_q <= 1'b0;
            cnt_en_q    <= 1'b0;
        end else begin
            buf_q       <= buf_d;
            wp_q        <= wp_d;
            sum_q       <= sum_d;
            fill_q      <= fill_d;
            avg_q       <= avg_d;
            avg_valid_q <= avg_valid_d;
            cnt_en_q    <= cnt_en_d;
        end
    end

    assign bus.avg_out    = avg_q;
    assign bus.avg_valid  = avg_valid_q;
    assign bus.cnt_en     = cnt_en_q;
    assign bus.fill_level = fill_q;
endmodule

// File: tb/tb_running_avg.sv
// Bench for running_avg (DATA_W=8, LOG2_WIN=3) with a window-model scoreboard.
module tb_running_avg;
    logic clk;
    logic clk_en;
    logic rst_n;

    running_avg_if #(.DATA_W(8), .LOG2_WIN(3)) bus ();

    running_avg #(.DATA_W(8), .LOG2_WIN(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 if (clk_en) clk = ~clk;

    int n_vec;
    int n_err;

    // Reference model: window contents, recomputed from scratch for each average.
    int mbuf [8];
    int mwp;
    int mfill;
    int mcnt;
    int mavg;
    int exp_q [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int model_avg();
        int s;
        int a;
        s = 0;
        for (int i = 0; i < 8; i++) s += mbuf[i];
`ifdef RUNNING_AVG_ROUND_EN
        a = (s + 4) / 8;
        if (a > 255) a = 255;
`else
        a = s / 8;
`endif
        return a;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 8; i++) mbuf[i] = 0;
        mwp   = 0;
        mfill = 0;
        mcnt  = 0;
    endtask

    // Apply one cycle of stimulus, then check outputs 1 time unit after the edge.
    task automatic step(input logic r, input logic v, input logic [7:0] d);
        logic pulse;
        int   e;
        pulse           = 1'b0;
        bus.run         = r;
        bus.sample_valid = v;
        bus.sample_in   = d;
        if (!r) begin
            model_clear();
        end else if (v) begin
            mbuf[mwp] = int'(d);
            mwp       = (mwp + 1) % 8;
            if (mfill < 8) mfill++;
            if (mfill == 8) begin
                pulse = 1'b1;
                exp_q.push_back(model_avg());
                mcnt = 1;
            end
        end
        @(posedge clk);
        #1;
        check("avg_valid", {31'd0, bus.avg_valid}, {31'd0, pulse});
        if (bus.avg_valid) begin
            check("q_nonempty", (exp_q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
            if (exp_q.size() > 0) begin
                e    = exp_q.pop_front();
                mavg = e;
                check("avg_out", {24'd0, bus.avg_out}, e);
            end
        end else begin
            if (pulse && exp_q.size() > 0) mavg = exp_q.pop_front();
            check("avg_hold", {24'd0, bus.avg_out}, mavg);
        end
        check("cnt_en", {31'd0, bus.cnt_en}, mcnt);
        check("fill_level", {28'd0, bus.fill_level}, mfill);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_avg"}, {24'd0, bus.avg_out}, 0);
        check({tag, "_valid"}, {31'd0, bus.avg_valid}, 0);
        check({tag, "_cnt"}, {31'd0, bus.cnt_en}, 0);
        check({tag, "_fill"}, {28'd0, bus.fill_level}, 0);
    endtask

    int t3 [8];

    initial begin
        n_vec = 0;
        n_err = 0;
        mavg  = 0;
        model_clear();
        clk_en           = 1'b0;
        rst_n            = 1'b1;
        bus.run          = 1'b0;
        bus.sample_valid = 1'b0;
        bus.sample_in    = '0;

        // 1: reset with clock stopped, then release
        #5 rst_n = 1'b0;
        #1 check_all_zero("rst_noclk");
        clk_en = 1'b1;
        #7 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'd99);

        // 2: fill with 10s
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 8'd10);
        check("t2_avg", {24'd0, bus.avg_out}, 10);
        check("t2_cnt", {31'd0, bus.cnt_en}, 1);

        // 3: step to 20s
`ifdef RUNNING_AVG_ROUND_EN
        t3 = '{11, 13, 14, 15, 16, 18, 19, 20};
`else
        t3 = '{11, 12, 13, 15, 16, 17, 18, 20};
`endif
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b1, 8'd20);
            check("t3_table", {24'd0, bus.avg_out}, t3[i]);
        end

        // 4: full-scale samples
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 8'd255);
        check("t4_max", {24'd0, bus.avg_out}, 255);

        // 5: gap keeps cnt_en, then flush collides with a sample
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'd1);
        step(1'b0, 1'b1, 8'd77);
        check("t5_fill", {28'd0, bus.fill_level}, 0);
        check("t5_cnt", {31'd0, bus.cnt_en}, 0);
        check("t5_hold", {24'd0, bus.avg_out}, 255);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 8'(40 + i));

        // random traffic
        for (int i = 0; i < 60; i++) begin
            step(($urandom_range(0, 15) != 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
                 8'($urandom_range(0, 255)));
        end

        // 6: async reset mid-window after a flush
        step(1'b0, 1'b0, 8'd0);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 8'd200);
        check("t6_fill5", {28'd0, bus.fill_level}, 5);
        #2 rst_n = 1'b0;
        #1 check_all_zero("rst_mid");
        model_clear();
        mavg = 0;
        exp_q.delete();
        #1 rst_n = 1'b1;
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 8'd16);
        check("t6_avg", {24'd0, bus.avg_out}, 16);
        step(1'b1, 1'b0, 8'd0);

        check("sb_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
